// File: rtl/bcd_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_timer_pkg
// Shared types and constants for the BCD countdown timer.
//   timer_state_t : run/stop FSM encoding (IDLE, RUN, DONE)
//   bcd_digit_t   : one packed BCD digit
//   BCD_MAX / BCD_MAX_TENS_SEC : wrap values for plain and seconds-tens digits
//   digit_max()   : wrap value of digit position idx for a given mm:ss mode
// -----------------------------------------------------------------------------
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } timer_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX          = 4'd9;
  localparam bcd_digit_t BCD_MAX_TENS_SEC = 4'd5;

  // Only digit 1 (tens of seconds) is mod-6 in mm:ss mode.
  function automatic bcd_digit_t digit_max(input int idx, input int mmss_mode);
    return (mmss_mode != 0 && idx == 1) ? BCD_MAX_TENS_SEC : BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// -----------------------------------------------------------------------------
// bcd_digit_cell
// One digit of the BCD down-counter with its own register.
//   clk, resetN  : clock, asynchronous active-low reset (digit -> 0)
//   borrow_in    : decrement request from the digit below (or the tick for digit 0)
//   max_val      : value the digit wraps to when it borrows from 0
//   load         : synchronous load, wins over borrow_in
//   load_val     : value loaded when load=1
//   digit        : current digit value
//   digit_dec    : value after a pending decrement, ignoring load
//   borrow_out   : digit==0 && borrow_in, forwarded to the next digit up
//   is_zero      : digit==0
// -----------------------------------------------------------------------------
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic       clk,
  input  logic       resetN,
  input  logic       borrow_in,
  input  bcd_digit_t max_val,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t digit,
  output bcd_digit_t digit_dec,
  output logic       borrow_out,
  output logic       is_zero
);

  bcd_digit_t digit_q, digit_d;

  // NOTE: digit_dec gets its default before the conditional update so every
  // path assigns it; without that this process would infer a latch.
  always_comb begin
    digit_dec = digit_q;
    if (borrow_in) begin
      digit_dec = (digit_q == 4'd0) ? max_val : digit_q - 4'd1;
    end
  end

  assign digit_d = load ? load_val : digit_dec;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process ordering.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit      = digit_q;
  assign is_zero    = (digit_q == 4'd0);
  assign borrow_out = borrow_in && (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// -----------------------------------------------------------------------------
// bcd_down_timer
// Multi-digit BCD countdown timer with a run/stop FSM (IDLE, RUN, DONE).
//   clk      : system clock
//   resetN   : asynchronous active-low reset
//   loadN    : synchronous active-low load of datain (count and shadow), -> IDLE
//   datain   : packed BCD preset, digit 0 in [3:0]; out-of-range digits clamp
//   start    : IDLE -> RUN when count != 0
//   pause    : level, freezes counting in RUN (ticks are dropped)
//   tick     : count-enable strobe, one decrement per tick in RUN
//   count    : packed BCD current value
//   tc       : combinational count == 0
//   running  : registered state == RUN
//   expired  : registered one-cycle pulse when a tick takes count to zero
//   warn     : (only with BCD_TIMER_WARN_EN) registered, RUN and
//              0 < count <= WARN_THRESH
// Configuration macro: BCD_TIMER_WARN_EN adds the warn output and compare.
// WARN_THRESH is BCD-packed, so the default 'h10 means ten.
// -----------------------------------------------------------------------------
module bcd_down_timer
  import bcd_timer_pkg::*;
#(
  parameter int                      NUM_DIGITS  = 3,
  parameter int                      MMSS_MODE   = 0,
  parameter int                      AUTO_RELOAD = 0,
  parameter logic [4*NUM_DIGITS-1:0] WARN_THRESH = (4*NUM_DIGITS)'(8'h10)
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    loadN,
  input  logic [4*NUM_DIGITS-1:0] datain,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    tc,
  output logic                    running,
  output logic                    expired
`ifdef BCD_TIMER_WARN_EN
  ,
  output logic                    warn
`endif
);

  localparam int W = 4 * NUM_DIGITS;

  timer_state_t          state_q, state_d;
  logic [W-1:0]          shadow_q, shadow_d;
  logic                  running_q, expired_q, expired_d;

  logic [W-1:0]          datain_clamped;
  logic [W-1:0]          count_dec;
  logic [W-1:0]          cell_load_val;
  logic                  cell_load;
  logic [NUM_DIGITS:0]   borrow;
  logic [NUM_DIGITS-1:0] digit_zero;
  logic                  dec_en, hit_zero, reload;
  logic                  top_borrow_unused;

  // loadN outranks everything; start only acts in IDLE, so tick needs only RUN.
  assign dec_en    = loadN && (state_q == ST_RUN) && tick && !pause;
  // Decrementing to zero is seen from the pre-load decrement result.
  assign hit_zero  = dec_en && (count_dec == '0);
  assign reload    = hit_zero && (AUTO_RELOAD != 0) && (shadow_q != '0);
  assign cell_load = !loadN || reload;
  assign cell_load_val = !loadN ? datain_clamped : shadow_q;

  assign borrow[0] = dec_en;
  // Count is never zero while RUN, so the top digit never borrows out.
  assign top_borrow_unused = borrow[NUM_DIGITS];

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam bcd_digit_t MaxVal = digit_max(i, MMSS_MODE);

    assign datain_clamped[4*i +: 4] =
      (datain[4*i +: 4] > MaxVal) ? MaxVal : datain[4*i +: 4];

    bcd_digit_cell u_cell (
      .clk        (clk),
      .resetN     (resetN),
      .borrow_in  (borrow[i]),
      .max_val    (MaxVal),
      .load       (cell_load),
      .load_val   (cell_load_val[4*i +: 4]),
      .digit      (count[4*i +: 4]),
      .digit_dec  (count_dec[4*i +: 4]),
      .borrow_out (borrow[i+1]),
      .is_zero    (digit_zero[i])
    );
  end

  assign tc = &digit_zero;

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    expired_d = 1'b0;
    if (!loadN) begin
      state_d  = ST_IDLE;
      shadow_d = datain_clamped;
    end else begin
      unique case (state_q)
        ST_IDLE: if (start && !tc) state_d = ST_RUN;
        ST_RUN: begin
          if (hit_zero) begin
            expired_d = 1'b1;
            if (!reload) state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= ST_IDLE;
      shadow_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      running_q <= (state_d == ST_RUN);
      expired_q <= expired_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;

`ifdef BCD_TIMER_WARN_EN
  logic [W-1:0] count_d;
  logic         warn_q;

  // Compare against next-cycle values so warn lines up with the count shown.
  // Valid packed BCD orders the same as its raw binary bits.
  assign count_d = cell_load ? cell_load_val : count_dec;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      warn_q <= 1'b0;
    end else begin
      warn_q <= (state_d == ST_RUN) && (count_d <= WARN_THRESH) && (count_d != '0);
    end
  end

  assign warn = warn_q;
`else
  localparam logic [W-1:0] WarnThreshUnused = WARN_THRESH;
`endif

endmodule
